// File: rtl/dmem_uart_responder.sv
// dmem_uart_responder
//   Data-memory-mapped UART transmitter with four 32-bit registers decoded on
//   d_addr[3:2]:
//     0 TXDATA  (write pushes wdata[7:0] when wmask[7:0] != 0, reads 0)
//     1 STATUS  ({29'b0, ovf, busy, full}; write 1 to bit 2 clears ovf)
//     2 DIVISOR (clocks per UART bit, bit-masked write of bits [15:0])
//     3 CYCLES  (free-running cycle counter, read-only)
//   Build option: define DMEM_UART_TXFIFO_EN for a 4-entry TX FIFO; without
//   it a single-byte holding register is used.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   d_cmd_start/write   command request and direction (1 = write)
//   d_cmd_ready         command can be accepted this cycle
//   d_addr/wdata/wmask  byte address, write data, per-bit write mask
//   rdata/rdata_valid   read data and its single-cycle valid pulse
//   uart_tx             8N1 serial output, idle high
module dmem_uart_responder #(
  parameter logic [15:0] DEFAULT_DIV = 16'd234
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_cmd_start,
  input  logic        d_cmd_write,
  output logic        d_cmd_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] wdata,
  input  logic [31:0] wmask,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        uart_tx
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]  state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  logic        ovf;
  logic [15:0] divisor;
  logic [31:0] cycles;

  logic        wr_acc;
  logic        rd_acc;
  logic [1:0]  sel;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_head;
  logic        busy;
  logic [15:0] bit_len_m1;
  logic [31:0] rd_mux;

  logic        unused_bits;
  assign unused_bits = ^{d_addr[31:4], d_addr[1:0], wdata[31:16], wmask[31:16]};

  assign sel      = d_addr[3:2];
  assign wr_acc   = d_cmd_start & d_cmd_ready & d_cmd_write;
  assign rd_acc   = d_cmd_start & d_cmd_ready & ~d_cmd_write;
  assign push_req = wr_acc && (sel == 2'd0) && (|wmask[7:0]);
  // Full is judged on the pre-cycle occupancy, so a same-cycle pop never
  // rescues a push into a full FIFO.
  assign push     = push_req && !fifo_full;
  assign pop      = (state == ST_IDLE) && !fifo_empty;
  assign busy     = !fifo_empty || (state != ST_IDLE);

  // A divisor of 0 behaves as 1 clock per bit.
  assign bit_len_m1 = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;

`ifdef DMEM_UART_TXFIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end

  assign fifo_full  = (count == 3'd4);
  assign fifo_empty = (count == 3'd0);
  assign fifo_head  = fifo_mem[rd_ptr];
`else
  logic [7:0] hold;
  logic       hold_valid;

  // Push needs an empty register and pop needs a full one, so they never
  // coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else if (push) begin
      hold       <= wdata[7:0];
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign fifo_full  = hold_valid;
  assign fifo_empty = !hold_valid;
  assign fifo_head  = hold;
`endif

  always_comb begin
    rd_mux = '0;
    case (sel)
      2'd0:    rd_mux = '0;
      2'd1:    rd_mux = {29'b0, ovf, busy, fifo_full};
      2'd2:    rd_mux = {16'b0, divisor};
      default: rd_mux = cycles;
    endcase
  end

  // Command side: ready drops only in the cycle a read response is shown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_cmd_ready <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      d_cmd_ready <= ~rd_acc;
      rdata_valid <= rd_acc;
      if (rd_acc) rdata <= rd_mux;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf     <= 1'b0;
      divisor <= DEFAULT_DIV;
      cycles  <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (push_req && fifo_full) begin
        ovf <= 1'b1;
      end else if (wr_acc && (sel == 2'd1) && wdata[2] && wmask[2]) begin
        ovf <= 1'b0;
      end
      if (wr_acc && (sel == 2'd2)) begin
        divisor <= (divisor & ~wmask[15:0]) | (wdata[15:0] & wmask[15:0]);
      end
    end
  end

  // Bit length is reloaded from the live divisor at each bit boundary, so a
  // divisor change applies from the next bit onward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state    <= ST_START;
            shreg    <= fifo_head;
            baud_cnt <= bit_len_m1;
            bit_idx  <= '0;
          end
        end
        ST_START: begin
          if (baud_cnt == 16'd0) begin
            state    <= ST_DATA;
            baud_cnt <= bit_len_m1;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_cnt == 16'd0) begin
            baud_cnt <= bit_len_m1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          if (baud_cnt == 16'd0) begin
            state <= ST_IDLE;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
      endcase
    end
  end

  // Decoded straight from state so reset forces the line high immediately.
  always_comb begin
    uart_tx = 1'b1;
    case (state)
      ST_START: uart_tx = 1'b0;
      ST_DATA:  uart_tx = shreg[0];
      default:  uart_tx = 1'b1;
    endcase
  end

endmodule
